// File: rtl/axi_lite_ram_slave_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axi_lite_ram_slave_pkg                                                     |
// | Shared response codes, FSM state and grant encodings for the RAM slave.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package axi_lite_ram_slave_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MEM  = 2'd1,
    RD_RESP = 2'd2,
    WR_RESP = 2'd3
  } ram_slave_state_t;

  typedef enum logic {
    GRANT_READ  = 1'b0,
    GRANT_WRITE = 1'b1
  } grant_t;

  function automatic logic [1:0] resp_for(input logic in_range);
    return in_range ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_lite_ram_slave_bram_sp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bram_sp                                                                    |
// | Single-port synchronous 32-bit RAM with byte write enables, 1-cycle read.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module bram_sp #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [3:0]            we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] r_mem [0:(1<<ADDR_WIDTH)-1];

  // No reset on the array or read register so the tools can map to block RAM.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) r_mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= r_mem[addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi_lite_ram_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axi_lite_ram_slave                                                         |
// | AXI4-Lite slave serialising reads/writes onto a single-port on-chip RAM.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module axi_lite_ram_slave
  import axi_lite_ram_slave_pkg::*;
#(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] axi_araddr,
  input  logic        axi_arvalid,
  output logic        axi_arready,
  input  logic [2:0]  axi_arprot,
  output logic [31:0] axi_rdata,
  output logic [1:0]  axi_rresp,
  output logic        axi_rvalid,
  input  logic        axi_rready,
  input  logic [31:0] axi_awaddr,
  input  logic        axi_awvalid,
  output logic        axi_awready,
  input  logic [2:0]  axi_awprot,
  input  logic [31:0] axi_wdata,
  input  logic [3:0]  axi_wstrb,
  input  logic        axi_wvalid,
  output logic        axi_wready,
  output logic [1:0]  axi_bresp,
  output logic        axi_bvalid,
  input  logic        axi_bready
);

  localparam logic [32:0] c_WINDOW = 33'd4 << ADDR_WIDTH;

  ram_slave_state_t      r_state, w_next_state;
  grant_t                r_last_grant;
  logic                  r_rdy_en;
  logic                  r_ar_held, r_aw_held, r_w_held;
  logic [31:0]           r_ar_addr, r_aw_addr, r_w_data;
  logic [3:0]            r_w_strb;
  logic                  r_rd_err;
  logic [1:0]            r_bresp;
  logic [31:0]           w_ar_off, w_aw_off;
  logic                  w_ar_in, w_aw_in, w_wr_req;
  logic                  w_grant_rd, w_grant_wr;
  logic                  w_ram_en;
  logic [3:0]            w_ram_we;
  logic [ADDR_WIDTH-1:0] w_ram_addr;
  logic [31:0]           w_ram_rdata;
  logic                  w_unused;

  // Subtraction may wrap; anything below BASE_ADDR lands far above the window.
  assign w_ar_off = r_ar_addr - BASE_ADDR;
  assign w_aw_off = r_aw_addr - BASE_ADDR;
  assign w_ar_in  = {1'b0, w_ar_off} < c_WINDOW;
  assign w_aw_in  = {1'b0, w_aw_off} < c_WINDOW;
  assign w_wr_req = r_aw_held & r_w_held;

  // r_rdy_en keeps all ready outputs low until the first edge after reset.
  assign axi_arready = r_rdy_en & ~r_ar_held;
  assign axi_awready = r_rdy_en & ~r_aw_held;
  assign axi_wready  = r_rdy_en & ~r_w_held;

  always_comb begin
    w_next_state = r_state;
    w_grant_rd   = 1'b0;
    w_grant_wr   = 1'b0;
    w_ram_en     = 1'b0;
    w_ram_we     = 4'b0000;
    w_ram_addr   = w_ar_off[ADDR_WIDTH+1:2];
    case (r_state)
      IDLE: begin
        if (r_ar_held && (!w_wr_req || r_last_grant == GRANT_WRITE)) begin
          w_grant_rd   = 1'b1;
          w_next_state = RD_MEM;
        end else if (w_wr_req) begin
          w_grant_wr   = 1'b1;
          w_next_state = WR_RESP;
          w_ram_en     = w_aw_in;
          w_ram_we     = w_aw_in ? r_w_strb : 4'b0000;
          w_ram_addr   = w_aw_off[ADDR_WIDTH+1:2];
        end
      end
      RD_MEM: begin
        w_ram_en     = w_ar_in;
        w_next_state = RD_RESP;
      end
      RD_RESP: if (axi_rready) w_next_state = IDLE;
      WR_RESP: if (axi_bready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_grant <= GRANT_WRITE;
      r_rdy_en     <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_rdy_en <= 1'b1;
      if (w_grant_rd) r_last_grant <= GRANT_READ;
      else if (w_grant_wr) r_last_grant <= GRANT_WRITE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ar_held <= 1'b0;
      r_ar_addr <= '0;
      r_aw_held <= 1'b0;
      r_aw_addr <= '0;
      r_w_held  <= 1'b0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
    end else begin
      if (axi_arvalid && axi_arready) begin
        r_ar_held <= 1'b1;
        r_ar_addr <= axi_araddr;
      end else if (r_state == RD_MEM) begin
        r_ar_held <= 1'b0;
      end
      if (axi_awvalid && axi_awready) begin
        r_aw_held <= 1'b1;
        r_aw_addr <= axi_awaddr;
      end else if (w_grant_wr) begin
        r_aw_held <= 1'b0;
      end
      if (axi_wvalid && axi_wready) begin
        r_w_held <= 1'b1;
        r_w_data <= axi_wdata;
        r_w_strb <= axi_wstrb;
      end else if (w_grant_wr) begin
        r_w_held <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_err <= 1'b0;
      r_bresp  <= AXI_RESP_OKAY;
    end else begin
      if (r_state == RD_MEM) r_rd_err <= ~w_ar_in;
      if (w_grant_wr) r_bresp <= resp_for(w_aw_in);
    end
  end

  // RAM read register holds while en is low, keeping rdata stable in RD_RESP.
  assign axi_rvalid = (r_state == RD_RESP);
  assign axi_rresp  = (axi_rvalid && r_rd_err) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  assign axi_rdata  = (axi_rvalid && !r_rd_err) ? w_ram_rdata : 32'h0;
  assign axi_bvalid = (r_state == WR_RESP);
  assign axi_bresp  = axi_bvalid ? r_bresp : AXI_RESP_OKAY;

  assign w_unused = ^{axi_arprot, axi_awprot, w_ar_off[1:0], w_ar_off[31:ADDR_WIDTH+2],
                      w_aw_off[1:0], w_aw_off[31:ADDR_WIDTH+2]};

  bram_sp #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .en    (w_ram_en),
    .we    (w_ram_we),
    .addr  (w_ram_addr),
    .wdata (r_w_data),
    .rdata (w_ram_rdata)
  );

endmodule
`default_nettype wire

// File: doc/axi_lite_ram_slave.md
Name: axi_lite_ram_slave

Overview:
- AXI4-Lite slave that terminates the memory master's five AXI channels on an on-chip single-port RAM (instruction + data memory).
- Sits directly downstream of the MMU's AXI master port.
- Serializes reads and writes onto one RAM port with round-robin arbitration.
- Applies byte strobes on writes and returns SLVERR for addresses outside its window.

Parameters:
- ADDR_WIDTH, 12: word-address bits; the RAM holds 2**ADDR_WIDTH 32-bit words (16 KiB).
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be 4-byte aligned.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- axi_araddr  in  32  read address.
- axi_arvalid  in  1  read address valid.
- axi_arready  out  1  read address ready.
- axi_arprot  in  3  ignored.
- axi_rdata  out  32  read data.
- axi_rresp  out  2  read response.
- axi_rvalid  out  1  read data valid.
- axi_rready  in  1  read data ready.
- axi_awaddr  in  32  write address.
- axi_awvalid  in  1  write address valid.
- axi_awready  out  1  write address ready.
- axi_awprot  in  3  ignored.
- axi_wdata  in  32  write data.
- axi_wstrb  in  4  byte enables; bit i covers wdata[8i+7:8i].
- axi_wvalid  in  1  write data valid.
- axi_wready  out  1  write data ready.
- axi_bresp  out  2  write response.
- axi_bvalid  out  1  write response valid.
- axi_bready  in  1  write response ready.

Behaviour:
- Reset (async, rst=1):
  - All holding registers are cleared.
  - State goes to IDLE.
  - arready/awready/wready=0 while rst is high; they rise on the first edge after release.
  - rvalid=bvalid=0, rdata=0, rresp=bresp=2'b00.
  - RAM contents are not reset.
  - Reset mid-transaction discards any held or in-flight request; a write already committed to RAM stays committed.
- Holding registers:
  - ar_held, aw_held, w_held, each with its payload.
  - arready = !ar_held; awready = !aw_held; wready = !w_held.
  - A channel handshake (valid&ready) sets its held flag and captures the payload on that edge.
  - AW and W may arrive in either order or the same cycle; a write is ready when aw_held && w_held.
- FSM states: IDLE, RD_MEM, RD_RESP, WR_RESP.
- IDLE:
  - Only a read ready -> RD_MEM.
  - Only a write ready -> WR_RESP; RAM write happens on this edge.
  - Both ready -> the class not granted last is taken; last_grant resets to WRITE, so the first tie goes to read.
  - Neither ready -> stay.
- RD_MEM:
  - RAM read issued using the held address.
  - Clears ar_held.
  - -> RD_RESP.
- RD_RESP:
  - rvalid=1; rdata and rresp are registered and stay stable until rready.
  - rvalid&rready -> IDLE, and rvalid drops the next cycle.
- WR_RESP:
  - bvalid=1 with bresp.
  - aw_held and w_held are cleared on entry.
  - bvalid&bready -> IDLE.
- Latency:
  - AR handshake at cycle 0 -> rvalid at cycle 3.
  - Last of AW/W handshakes at cycle 0 -> bvalid at cycle 2.
  - Zero-wait-state back-to-back reads give one read per 3 cycles.
- Address decode:
  - off = addr - BASE_ADDR (32-bit, wrap allowed).
  - In range iff off < 4 * 2**ADDR_WIDTH; word index = off[ADDR_WIDTH+1:2].
  - addr[1:0] is ignored; no misalignment error.
- Out of range:
  - Read returns rdata=0, rresp=2'b10 (SLVERR).
  - Write leaves RAM unmodified, bresp=2'b10.
  - In range: OKAY (2'b00).
- Write strobes:
  - Only bytes with wstrb=1 change.
  - wstrb=4'b0000 is a legal no-op and returns OKAY.
- A new request may be captured while a response is pending (held registers), but is not serviced until the FSM returns to IDLE.
- Responses are never reordered; at most one outstanding response exists.

Decomposition:
- Shared package (def.sv):
  - AXI_RESP_OKAY=2'b00, AXI_RESP_SLVERR=2'b10.
  - FSM state enum: ram_slave_state_t.
  - Grant encoding: GRANT_READ / GRANT_WRITE.
- Sub-module bram_sp:
  - Single-port synchronous RAM, parameter ADDR_WIDTH.
  - Ports: en, we[3:0], addr, wdata, rdata.
  - 1-cycle read latency, written to infer block RAM.

Test Plan:
- Reset release, then AW+W same cycle: addr 0x10, data 0xDEADBEEF, strb 4'hF; then AR 0x10 -> bvalid at +2 with bresp 00; rvalid at +3 with rdata 0xDEADBEEF, rresp 00.
- W before AW by 3 cycles: data 0x000000AA, strb 4'b0001 to 0x10 (holding 0xDEADBEEF) -> read returns 0xDEADBEAA; awready stays high until AW arrives, wready low after W.
- arvalid and aw/w pending in the same IDLE cycle, repeated 4 times -> service order R,W,R,W; no lost or duplicate responses.
- AR at BASE_ADDR + 0x4000 (ADDR_WIDTH=12) -> rresp 10, rdata 0; write to the same address -> bresp 10, and RAM word 0 unchanged.
- rready held low 5 cycles in RD_RESP -> rvalid stays 1, rdata stable, arready reflects ar_held; then rready=1 -> rvalid 0 next cycle.
- rst asserted in WR_RESP and in RD_MEM -> bvalid/rvalid drop immediately; after release all ready signals are 1 and the RAM retains the committed write.
